// File: rtl/keyboard_input_pkg.sv
// Shared PS/2 keyboard constants: button codes, direction indices, scan codes
// and the key-map lookup used by keyboard_input (and GameScene).
package keyboard_input_pkg;

    localparam logic [4:0] BTN_NONE  = 5'b00000;
    localparam logic [4:0] BTN_UP    = 5'b00001;
    localparam logic [4:0] BTN_DOWN  = 5'b00010;
    localparam logic [4:0] BTN_LEFT  = 5'b00100;
    localparam logic [4:0] BTN_RIGHT = 5'b01000;
    localparam logic [4:0] BTN_FIRE  = 5'b10000;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;
    localparam int DIR_FIRE  = 4;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_XUP   = 8'h75;
    localparam logic [7:0] SC_XDOWN = 8'h72;
    localparam logic [7:0] SC_XLEFT = 8'h6B;
    localparam logic [7:0] SC_XRGHT = 8'h74;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    // Held-key mask: bits [4:0] player 1, [9:5] player 2; zero if unmapped.
    function automatic logic [9:0] key_mask(input logic ext, input logic [7:0] code);
        logic [9:0] m;
        m = '0;
        if (!ext) begin
            case (code)
                SC_W:     m[DIR_UP]       = 1'b1;
                SC_S:     m[DIR_DOWN]     = 1'b1;
                SC_A:     m[DIR_LEFT]     = 1'b1;
                SC_D:     m[DIR_RIGHT]    = 1'b1;
                SC_SPACE: m[DIR_FIRE]     = 1'b1;
                SC_ENTER: m[5 + DIR_FIRE] = 1'b1;
                default:  m = '0;
            endcase
        end else begin
            case (code)
                SC_XUP:   m[5 + DIR_UP]    = 1'b1;
                SC_XDOWN: m[5 + DIR_DOWN]  = 1'b1;
                SC_XLEFT: m[5 + DIR_LEFT]  = 1'b1;
                SC_XRGHT: m[5 + DIR_RIGHT] = 1'b1;
                default:  m = '0;
            endcase
        end
        return m;
    endfunction

    function automatic logic [4:0] prio_btn(input logic [4:0] h);
        if (h[DIR_UP])         return BTN_UP;
        else if (h[DIR_DOWN])  return BTN_DOWN;
        else if (h[DIR_LEFT])  return BTN_LEFT;
        else if (h[DIR_RIGHT]) return BTN_RIGHT;
        else if (h[DIR_FIRE])  return BTN_FIRE;
        return BTN_NONE;
    endfunction

endpackage

// File: rtl/keyboard_input_ps2_rx.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, 11-bit frame
// assembly with start/parity/stop check, inter-edge timeout.
module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       clk_25m,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       rx_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]    clk_sync_q;   // [0],[1] synchronizer, [2] previous for edge
    logic [1:0]    dat_sync_q;
    logic [3:0]    bit_cnt_q;
    logic [8:0]    shift_q;
    logic [TW-1:0] tmo_q;
    logic          byte_valid_q;
    logic [7:0]    byte_q;
    logic          err_q;

    logic fall, dat;
    assign fall = clk_sync_q[2] & ~clk_sync_q[1];
    assign dat  = dat_sync_q[1];

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q   <= '1;
            dat_sync_q   <= '1;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            clk_sync_q   <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q   <= {dat_sync_q[0], ps2_data};
            byte_valid_q <= 1'b0;
            err_q        <= 1'b0;
            if (fall) begin
                tmo_q <= '0;
                if (bit_cnt_q == 4'd0) begin
                    if (!dat) bit_cnt_q <= 4'd1;
                    else      err_q     <= 1'b1;
                end else if (bit_cnt_q < 4'd10) begin
                    // 8 data bits LSB first then parity; data lands in [7:0]
                    shift_q   <= {dat, shift_q[8:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end else begin
                    bit_cnt_q <= 4'd0;
                    if (dat && (^shift_q)) begin
                        byte_valid_q <= 1'b1;
                        byte_q       <= shift_q[7:0];
                    end else begin
                        err_q <= 1'b1;
                    end
                end
            end else if (bit_cnt_q != 4'd0) begin
                if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    bit_cnt_q <= 4'd0;
                    tmo_q     <= '0;
                    err_q     <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end
        end
    end

    assign byte_valid = byte_valid_q;
    assign rx_byte    = byte_q;
    assign rx_err     = err_q;

endmodule

// File: rtl/keyboard_input.sv
// PS/2 keyboard to two-player button decoder: prefix FSM, key map,
// held-key register and per-player priority encode.
module keyboard_input
    import keyboard_input_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       clk_25m,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [4:0] player1_btns,
    output logic [4:0] player2_btns
);
    logic       byte_valid, rx_err;
    logic [7:0] rx_byte;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk_25m    (clk_25m),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .rx_err     (rx_err)
    );

    dec_state_e state_q, state_d;
    logic [9:0] held_q, held_d;
    logic [4:0] p1_q, p2_q;
    logic       ext, brk;
    logic [9:0] mask;

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            held_q  <= '0;
            p1_q    <= BTN_NONE;
            p2_q    <= BTN_NONE;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            p1_q    <= prio_btn(held_q[4:0]);
            p2_q    <= prio_btn(held_q[9:5]);
        end
    end

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        ext     = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        brk     = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        mask    = key_mask(ext, rx_byte);
        // A framing error or timeout abandons any pending prefix
        if (rx_err) begin
            state_d = ST_IDLE;
        end else if (byte_valid) begin
            if (state_q == ST_IDLE && rx_byte == PS2_EXT) begin
                state_d = ST_EXT;
            end else if (rx_byte == PS2_BRK && state_q == ST_IDLE) begin
                state_d = ST_BRK;
            end else if (rx_byte == PS2_BRK && state_q == ST_EXT) begin
                state_d = ST_EXT_BRK;
            end else begin
                state_d = ST_IDLE;
                held_d  = brk ? (held_q & ~mask) : (held_q | mask);
            end
        end
    end

    assign player1_btns = p1_q;
    assign player2_btns = p2_q;

endmodule

// File: tb/tb_keyboard_input.sv
// Directed bench for keyboard_input: drives PS/2 frames and checks buttons.
module tb_keyboard_input;
    logic       clk_25m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [4:0] player1_btns, player2_btns;

    int total = 0;
    int bad   = 0;

    localparam int HALF = 10;

    keyboard_input #(.TIMEOUT_CYCLES(25000)) dut (
        .clk_25m      (clk_25m),
        .rst_n        (rst_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .player1_btns (player1_btns),
        .player2_btns (player2_btns)
    );

    always #20 clk_25m = ~clk_25m;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_25m);
            ps2_data = v[i];
            repeat (HALF) @(negedge clk_25m);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk_25m);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk_25m);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par);
        logic [10:0] v;
        v = {1'b1, (~^b) ^ flip_par, b, 1'b0};
        send_bits(v, 11);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk_25m);
    endtask

    initial begin
        repeat (3) @(negedge clk_25m);
        chk("reset_p1", player1_btns, 5'b00000);
        chk("reset_p2", player2_btns, 5'b00000);
        rst_n = 1'b1;
        settle();

        // W make then break
        send_frame(8'h1D, 0); settle();
        chk("w_make_p1", player1_btns, 5'b00001);
        chk("w_make_p2", player2_btns, 5'b00000);
        send_frame(8'hF0, 0); send_frame(8'h1D, 0); settle();
        chk("w_brk_p1", player1_btns, 5'b00000);
        chk("w_brk_p2", player2_btns, 5'b00000);

        // Space held, extended left for player 2
        send_frame(8'h29, 0); settle();
        chk("space_p1", player1_btns, 5'b10000);
        send_frame(8'hE0, 0); send_frame(8'h6B, 0); settle();
        chk("xleft_p2", player2_btns, 5'b00100);
        chk("xleft_p1", player1_btns, 5'b10000);
        send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h6B, 0); settle();
        chk("xleft_brk_p2", player2_btns, 5'b00000);
        chk("xleft_brk_p1", player1_btns, 5'b10000);
        send_frame(8'hF0, 0); send_frame(8'h29, 0); settle();
        chk("space_brk_p1", player1_btns, 5'b00000);

        // Priority: A then W, release W
        send_frame(8'h1C, 0); settle();
        chk("a_p1", player1_btns, 5'b00100);
        send_frame(8'h1D, 0); settle();
        chk("a_w_p1", player1_btns, 5'b00001);
        send_frame(8'hF0, 0); send_frame(8'h1D, 0); settle();
        chk("a_only_p1", player1_btns, 5'b00100);
        send_frame(8'hF0, 0); send_frame(8'h1C, 0); settle();
        chk("a_brk_p1", player1_btns, 5'b00000);

        // Parity error dropped, next frame fine
        send_frame(8'h1D, 1); settle();
        chk("par_err_p1", player1_btns, 5'b00000);
        send_frame(8'h1B, 0); settle();
        chk("s_p1", player1_btns, 5'b00010);
        send_frame(8'hF0, 0); send_frame(8'h1B, 0); settle();
        chk("s_brk_p1", player1_btns, 5'b00000);

        // Non-extended 75 must not map to player 2 up
        send_frame(8'h75, 0); settle();
        chk("nonext75_p2", player2_btns, 5'b00000);
        chk("nonext75_p1", player1_btns, 5'b00000);

        // F0 prefix then a framing error: next 1D is a make, not a break
        send_frame(8'hF0, 0); send_frame(8'h44, 1); send_frame(8'h1D, 0); settle();
        chk("brk_err_make_p1", player1_btns, 5'b00001);
        // Typematic repeat then a single break clears
        send_frame(8'h1D, 0); send_frame(8'h1D, 0); settle();
        chk("repeat_p1", player1_btns, 5'b00001);
        send_frame(8'hF0, 0); send_frame(8'h1D, 0); settle();
        chk("repeat_brk_p1", player1_btns, 5'b00000);

        // Both players at once
        send_frame(8'h1D, 0); send_frame(8'hE0, 0); send_frame(8'h72, 0); settle();
        chk("both_p1", player1_btns, 5'b00001);
        chk("both_p2", player2_btns, 5'b00010);
        send_frame(8'hF0, 0); send_frame(8'h1D, 0);
        send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h72, 0); settle();
        chk("both_rel_p1", player1_btns, 5'b00000);
        chk("both_rel_p2", player2_btns, 5'b00000);

        // Partial frame then timeout, then Enter
        send_bits(11'b000_0000_1010, 5);
        repeat (25100) @(negedge clk_25m);
        send_frame(8'h5A, 0); settle();
        chk("tmo_enter_p2", player2_btns, 5'b10000);
        chk("tmo_enter_p1", player1_btns, 5'b00000);
        send_frame(8'hF0, 0); send_frame(8'h5A, 0); settle();
        chk("enter_brk_p2", player2_btns, 5'b00000);

        // Reset mid-frame while W held
        send_frame(8'h1D, 0); settle();
        chk("pre_rst_p1", player1_btns, 5'b00001);
        send_bits(11'b000_0001_0110, 4);
        @(negedge clk_25m);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_p1", player1_btns, 5'b00000);
        chk("rst_mid_p2", player2_btns, 5'b00000);
        repeat (3) @(negedge clk_25m);
        rst_n = 1'b1;
        settle();
        send_frame(8'h23, 0); settle();
        chk("post_rst_d_p1", player1_btns, 5'b01000);
        chk("post_rst_d_p2", player2_btns, 5'b00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
